// File: rtl/display_scan_ctrl_pkg.sv
// Shared display definitions: arbitration state encoding, blank-display
// constants and the per-frame snapshot record.
package display_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } own_state_e;

  // Dot/blank bits are active-high "off", so all-ones is a dark display.
  localparam logic [15:0] BLANK_HEXS  = 16'h0000;
  localparam logic [3:0]  BLANK_POINT = 4'hF;
  localparam logic [3:0]  BLANK_LES   = 4'hF;

  typedef struct packed {
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
  } snap_t;

  localparam snap_t BLANK_SNAP = '{hexs: BLANK_HEXS, point: BLANK_POINT, les: BLANK_LES};

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// scan_timer: digit-slot prescaler plus 2-bit scan counter.
//   clk, rst_n  : clock, async active-low reset
//   Scan        : current digit slot 0..3
//   tick        : one-cycle pulse on the last clk of every slot
//   frame_done  : one-cycle pulse on the last clk of slot 3
module scan_timer #(
  parameter int DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] Scan,
  output logic       tick,
  output logic       frame_done
);

  localparam int              CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick       = (cnt == CNT_MAX);
  assign frame_done = tick && (Scan == 2'd3);

  // Scan wraps 3->0 through natural 2-bit overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      Scan <= 2'd0;
    end else if (tick) begin
      cnt  <= '0;
      Scan <= Scan + 2'd1;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: arbitrates a 4-digit display between requesters A and B
// and presents a frame-stable snapshot of the owner's digits.
//   clk, rst_n                  : clock, async active-low reset
//   req_a/b                     : ownership requests (level, sampled at frame end)
//   hexs_a/b, point_a/b, les_a/b: requester digit, dot and blank fields
//   Scan                        : digit slot to the downstream multiplexer
//   Hexs, Point, Les            : owner snapshot, reloaded only at frame end
//   gnt_a, gnt_b                : registered owner indication
//   frame_done                  : pulse on the last clk of slot 3
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIV         = 100000,
  parameter int HOLD_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] hexs_a,
  input  logic [15:0] hexs_b,
  input  logic [3:0]  point_a,
  input  logic [3:0]  point_b,
  input  logic [3:0]  les_a,
  input  logic [3:0]  les_b,
  output logic [1:0]  Scan,
  output logic [15:0] Hexs,
  output logic [3:0]  Point,
  output logic [3:0]  Les,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        frame_done
);

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);

  own_state_e state, state_nxt;
  logic [7:0] hold, hold_inc;
  snap_t      snap_nxt;
  logic       tick_unused;  // only frame boundaries matter here

  scan_timer #(.DIV(DIV)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .Scan       (Scan),
    .tick       (tick_unused),
    .frame_done (frame_done)
  );

  // hold counts frames completed under the current owner. The contested
  // hand-over uses the count including the frame just ending, so an owner
  // keeps the display for exactly HOLD_FRAMES frames when both request.
  always_comb begin
    hold_inc  = (hold == HOLD_MAX) ? hold : hold + 8'd1;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_a)      state_nxt = OWN_A;
        else if (req_b) state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                           state_nxt = req_b ? OWN_B : IDLE;
        else if (req_b && hold_inc == HOLD_MAX) state_nxt = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                           state_nxt = req_a ? OWN_A : IDLE;
        else if (req_a && hold_inc == HOLD_MAX) state_nxt = OWN_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap_nxt = BLANK_SNAP;
    case (state_nxt)
      OWN_A:   snap_nxt = '{hexs: hexs_a, point: point_a, les: les_a};
      OWN_B:   snap_nxt = '{hexs: hexs_b, point: point_b, les: les_b};
      default: snap_nxt = BLANK_SNAP;
    endcase
  end

  // Everything visible moves together on the frame boundary edge, which is
  // also the edge that returns Scan to 0, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= 8'd0;
      Hexs  <= BLANK_HEXS;
      Point <= BLANK_POINT;
      Les   <= BLANK_LES;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
    end else if (frame_done) begin
      state <= state_nxt;
      hold  <= (state_nxt != state || state_nxt == IDLE) ? 8'd0 : hold_inc;
      Hexs  <= snap_nxt.hexs;
      Point <= snap_nxt.point;
      Les   <= snap_nxt.les;
      gnt_a <= (state_nxt == OWN_A);
      gnt_b <= (state_nxt == OWN_B);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (DIV=4, HOLD_FRAMES=2).
// A frame-level reference model predicts the snapshot at each frame boundary;
// a monitor pops it when the DUT signals frame_done and checks every cycle.
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int HOLD  = 2;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic        ga;
    logic        gb;
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
  } exp_t;

  localparam exp_t RST_EXP = {1'b0, 1'b0, 16'h0000, 4'hF, 4'hF};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] hexs_a = 16'h0, hexs_b = 16'h0;
  logic [3:0]  point_a = 4'h0, point_b = 4'h0, les_a = 4'h0, les_b = 4'h0;
  logic [1:0]  Scan;
  logic [15:0] Hexs;
  logic [3:0]  Point, Les;
  logic        gnt_a, gnt_b, frame_done;

  display_scan_ctrl #(.DIV(DIV), .HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .hexs_a(hexs_a), .hexs_b(hexs_b), .point_a(point_a), .point_b(point_b),
    .les_a(les_a), .les_b(les_b), .Scan(Scan), .Hexs(Hexs), .Point(Point),
    .Les(Les), .gnt_a(gnt_a), .gnt_b(gnt_b), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  int   k = 0;       // rising edges since reset release
  int   owner = 0;   // 0 none, 1 A, 2 B
  int   owned = 0;   // frames completed under current owner

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: decides the owner of the next frame from the request
  // levels present at the boundary edge and the frames already owned.
  task automatic boundary();
    int   nxt;
    exp_t e;
    nxt = owner;
    case (owner)
      0: nxt = req_a ? 1 : (req_b ? 2 : 0);
      1: if (!req_a) nxt = req_b ? 2 : 0;
         else if (req_b && owned + 1 >= HOLD) nxt = 2;
      default: if (!req_b) nxt = req_a ? 1 : 0;
         else if (req_a && owned + 1 >= HOLD) nxt = 1;
    endcase
    if (nxt != owner || nxt == 0) owned = 0;
    else owned++;
    owner = nxt;
    if (nxt == 1)      e = {1'b1, 1'b0, hexs_a, point_a, les_a};
    else if (nxt == 2) e = {1'b0, 1'b1, hexs_b, point_b, les_b};
    else               e = RST_EXP;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0; owner = 0; owned = 0;
        q.delete();
      end else begin
        if (k % FRAME == FRAME - 1) boundary();
        k++;
      end
    end
  end

  // Monitor
  initial begin
    exp_t cur;
    logic fd_prev;
    cur = RST_EXP;
    fd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur = RST_EXP;
        fd_prev = 1'b0;
      end else begin
        if (fd_prev) begin
          if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL pop: frame_done with no expected snapshot at %0t", $time);
          end else cur = q.pop_front();
        end
        chk("scan", 32'(Scan), 32'((k / DIV) % 4));
        chk("frame_done", 32'(frame_done), 32'(k % FRAME == FRAME - 1));
        chk("snapshot", 32'({gnt_a, gnt_b, Hexs, Point, Les}), 32'(cur));
        chk("gnt_onehot", 32'(gnt_a & gnt_b), 32'd0);
        fd_prev = frame_done;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_phase(input int ph);
    @(negedge clk);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != ph; i++) @(negedge clk);
  endtask

  task automatic wait_owner(input int o);
    for (int i = 0; i < 8 * FRAME && owner != o; i++) @(negedge clk);
    if (owner != o) begin
      n_cmp++; n_err++;
      $display("FAIL wait_owner: owner %0d want %0d (timeout)", owner, o);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_scan", 32'(Scan), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_snap", 32'({gnt_a, gnt_b, Hexs, Point, Les}), 32'(RST_EXP));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_pulse();
    // idle frames: blank display, no grant
    cycles(2 * FRAME + 3);
    // A requests mid-frame; later changes its digits mid-frame
    to_phase(6);
    req_a = 1'b1; hexs_a = 16'h1234; point_a = 4'h5; les_a = 4'h0;
    wait_owner(1);
    to_phase(6);
    hexs_a = 16'h5678;
    cycles(2 * FRAME);
    // both request: alternate every HOLD frames
    req_b = 1'b1; hexs_b = 16'hBEEF; point_b = 4'hA; les_b = 4'h2;
    cycles(8 * FRAME);
    // owner A drops while B requests
    wait_owner(1);
    to_phase(7);
    req_a = 1'b0;
    cycles(3 * FRAME);
    // randomized stretch
    repeat (60 * FRAME) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) req_a = ~req_a;
      if ($urandom_range(0, 11) == 0) req_b = ~req_b;
      if ($urandom_range(0, 3) == 0) begin
        hexs_a = 16'($urandom); point_a = 4'($urandom); les_a = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        hexs_b = 16'($urandom); point_b = 4'($urandom); les_b = 4'($urandom);
      end
    end
    // both drop -> idle
    to_phase(6);
    req_a = 1'b0; req_b = 1'b0;
    cycles(2 * FRAME);
    // B owns, reset lands in slot 2
    req_b = 1'b1; hexs_b = 16'hC0DE;
    wait_owner(2);
    to_phase(9);
    reset_pulse();
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    cycles(3 * FRAME);
    to_phase(4);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
